sar_adc_emulator: RTL

//   Digital stand-in for the analog half of the 8-bit SAR ADC: sample-and-hold, DAC and comparator.

---
 rtl/sar_adc_emulator_if.sv | 24 ++
 rtl/sar_adc_emulator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sar_adc_emulator_if.sv
// SAR-side link between the ADC emulator (master) and the SAR controller (slave).
// Signal names are seen from the emulator: it receives trial/done and drives comp/reset.
interface sar_adc_emulator_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] trial_i;
    logic              done_i;
    logic              comp_o;
    logic              sar_rst_n_o;

    modport master (
        input  trial_i,
        input  done_i,
        output comp_o,
        output sar_rst_n_o
    );

    modport slave (
        output trial_i,
        output done_i,
        input  comp_o,
        input  sar_rst_n_o
    );
endinterface

// File: rtl/sar_adc_emulator.sv
// Digital stand-in for the SAR ADC analog front end: sample-and-hold, DAC compare and result check.
// Optional feature: define SAR_EMU_LFSR_EN to take samples from an internal 16-bit LFSR.
module sar_adc_emulator #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run_i,
    input  logic                  clr_i,
    input  logic [DATA_W-1:0]     sample_i,
    sar_adc_emulator_if.master    sar,
    output logic                  busy_o,
    output logic                  conv_done_o,
    output logic                  err_o,
    output logic                  timeout_o,
    output logic [DATA_W-1:0]     sample_o,
    output logic [CNT_W-1:0]      pass_cnt_o,
    output logic [CNT_W-1:0]      fail_cnt_o
);

    localparam int unsigned     TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_CONVERT,
        S_CHECK,
        S_CHECK_TO
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   pass_q, pass_d;
    logic [CNT_W-1:0]   fail_q, fail_d;
    logic               err_q, err_d;
    logic               to_q, to_d;
    logic               sar_rst_n_q;
    logic               busy_q;
    logic               done_q;
    logic [DATA_W-1:0]  src_val;

`ifdef SAR_EMU_LFSR_EN
    // x^16+x^14+x^13+x^11+1, advanced once per SAMPLE; the pre-step value is sampled
    logic [15:0] lfsr_q, lfsr_d;
    logic        lfsr_fb;
    logic        unused_in;

    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign src_val   = lfsr_q[DATA_W-1:0];
    assign unused_in = ^sample_i;

    always_comb begin
        lfsr_d = lfsr_q;
        if (state_q == S_SAMPLE) begin
            lfsr_d = {lfsr_q[14:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic unused_in;

    assign src_val   = sample_i;
    assign unused_in = ^LFSR_SEED;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Next-state, timer, counters and sticky flags
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        tmr_d    = tmr_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        err_d    = err_q;
        to_d     = to_q;

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                sample_d = src_val;
                tmr_d    = '0;
                state_d  = S_CONVERT;
            end
            S_CONVERT: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (sar.done_i) begin
                    state_d = S_CHECK;
                end else if (tmr_q == TMR_LAST) begin
                    to_d    = 1'b1;
                    fail_d  = sat_inc(fail_q);
                    state_d = S_CHECK_TO;
                end
            end
            S_CHECK: begin
                if (sar.trial_i == sample_q) begin
                    pass_d = sat_inc(pass_q);
                end else begin
                    fail_d = sat_inc(fail_q);
                    err_d  = 1'b1;
                end
                state_d = run_i ? S_SAMPLE : S_IDLE;
            end
            S_CHECK_TO: begin
                state_d = run_i ? S_SAMPLE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Clear has priority over any same-cycle increment or flag set
        if (clr_i) begin
            pass_d = '0;
            fail_d = '0;
            err_d  = 1'b0;
            to_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sample_q    <= '0;
            tmr_q       <= '0;
            pass_q      <= '0;
            fail_q      <= '0;
            err_q       <= 1'b0;
            to_q        <= 1'b0;
            sar_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_q    <= sample_d;
            tmr_q       <= tmr_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            err_q       <= err_d;
            to_q        <= to_d;
            // Status outputs are registered from the next state so they align with it
            sar_rst_n_q <= (state_d == S_CONVERT);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_CHECK) || (state_d == S_CHECK_TO);
        end
    end

    // Comparator answer must be same-cycle with the trial code
    assign sar.comp_o      = (state_q == S_CONVERT) && (sample_q >= sar.trial_i);
    assign sar.sar_rst_n_o = sar_rst_n_q;
    assign busy_o          = busy_q;
    assign conv_done_o     = done_q;
    assign err_o           = err_q;
    assign timeout_o       = to_q;
    assign sample_o        = sample_q;
    assign pass_cnt_o      = pass_q;
    assign fail_cnt_o      = fail_q;

endmodule
